// File: rtl/mesm6_memctl.sv
// Single-port RAM controller for the MESM-6 CPU. It arbitrates the instruction
// and data buses and runs one RAM access at a time.
module mesm6_memctl #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ibus_fetch,
    input  logic [14:0] ibus_addr,
    output logic [47:0] ibus_input,
    output logic        ibus_done,

    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [14:0] dbus_addr,
    input  logic [47:0] dbus_output,
    output logic [47:0] dbus_input,
    output logic        dbus_done,

    output logic [14:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [47:0] mem_wdata,
    input  logic [47:0] mem_rdata,

    output logic        proto_err
);

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {T_IFETCH, T_DREAD, T_DWRITE} txn_t;

    state_t      state_reg, state_next;
    txn_t        type_reg;
    logic [2:0]  cnt_reg;
    logic        fetch_lost_reg;

    logic [14:0] mem_addr_reg;
    logic [47:0] mem_wdata_reg;
    logic        mem_rd_reg, mem_wr_reg;
    logic [47:0] ibus_input_reg, dbus_input_reg;
    logic        ibus_done_reg, dbus_done_reg;

    logic        data_req;
    logic        grant_valid;
    txn_t        grant_type;
    logic [14:0] grant_addr;

    // Arbitration and next-state logic
    always_comb begin
        state_next  = state_reg;
        data_req    = dbus_read | dbus_write;
        grant_valid = 1'b0;
        grant_type  = T_IFETCH;
        grant_addr  = ibus_addr;

        unique case (state_reg)
            IDLE: begin
                // Data normally wins; a fetch that just lost is served next.
                if (ibus_fetch && (!data_req || fetch_lost_reg)) begin
                    grant_valid = 1'b1;
                    grant_type  = T_IFETCH;
                    grant_addr  = ibus_addr;
                end else if (data_req) begin
                    grant_valid = 1'b1;
                    grant_type  = dbus_write ? T_DWRITE : T_DREAD;
                    grant_addr  = dbus_addr;
                end
                if (grant_valid)
                    state_next = ISSUE;
            end
            ISSUE: state_next = (type_reg == T_DWRITE) ? DONE : WAIT;
            WAIT:  if (cnt_reg == 3'd1) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            type_reg       <= T_IFETCH;
            cnt_reg        <= 3'd0;
            fetch_lost_reg <= 1'b0;
            mem_addr_reg   <= 15'd0;
            mem_wdata_reg  <= 48'd0;
            mem_rd_reg     <= 1'b0;
            mem_wr_reg     <= 1'b0;
            ibus_input_reg <= 48'd0;
            dbus_input_reg <= 48'd0;
            ibus_done_reg  <= 1'b0;
            dbus_done_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            ibus_done_reg <= 1'b0;
            dbus_done_reg <= 1'b0;

            unique case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        type_reg       <= grant_type;
                        mem_addr_reg   <= grant_addr;
                        mem_wdata_reg  <= dbus_output;
                        mem_rd_reg     <= (grant_type != T_DWRITE);
                        mem_wr_reg     <= (grant_type == T_DWRITE);
                        fetch_lost_reg <= ibus_fetch && (grant_type != T_IFETCH);
                    end
                end
                ISSUE: begin
                    cnt_reg <= LAT;
                    if (type_reg == T_DWRITE)
                        dbus_done_reg <= 1'b1;
                end
                WAIT: begin
                    // Counter reaches 1 in the cycle the RAM presents its data.
                    if (cnt_reg == 3'd1) begin
                        if (type_reg == T_IFETCH) begin
                            ibus_input_reg <= mem_rdata;
                            ibus_done_reg  <= 1'b1;
                        end else begin
                            dbus_input_reg <= mem_rdata;
                            dbus_done_reg  <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    assign ibus_input = ibus_input_reg;
    assign ibus_done  = ibus_done_reg;
    assign dbus_input = dbus_input_reg;
    assign dbus_done  = dbus_done_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_rd     = mem_rd_reg;
    assign mem_wr     = mem_wr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign proto_err  = !reset && (state_reg == IDLE) && dbus_read && dbus_write;

endmodule

// File: tb/tb_mesm6_memctl.sv
// Randomized bench for mesm6_memctl: two instances (latency 1 and 7) against a
// transaction-level model of arbitration, latency and RAM contents.
module tb_mesm6_memctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset       [2];
    logic        ibus_fetch  [2];
    logic [14:0] ibus_addr   [2];
    logic [47:0] ibus_input  [2];
    logic        ibus_done   [2];
    logic        dbus_read   [2];
    logic        dbus_write  [2];
    logic [14:0] dbus_addr   [2];
    logic [47:0] dbus_output [2];
    logic [47:0] dbus_input  [2];
    logic        dbus_done   [2];
    logic [14:0] mem_addr    [2];
    logic        mem_rd      [2];
    logic        mem_wr      [2];
    logic [47:0] mem_wdata   [2];
    logic [47:0] mem_rdata   [2];
    logic        proto_err   [2];

    int checks = 0;
    int failures = 0;

    // Model state: RAM image (stored xor'd with a per-address seed), last
    // captured words, and whether a fetch lost the previous arbitration.
    bit   [47:0] model_ram [2][32768];
    logic [47:0] exp_ibus  [2];
    logic [47:0] exp_dbus  [2];
    bit          lost_m    [2];

    function automatic logic [47:0] init_word(input logic [14:0] a);
        return {a, ~a, a[7:0], a[9:0]};
    endfunction

    function automatic logic [47:0] model_get(input int k, input logic [14:0] a);
        return model_ram[k][a] ^ init_word(a);
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 7;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 7;
        bit   [47:0] ram  [32768];
        logic [47:0] pipe [7];

        // RAM environment: returns data exactly LAT cycles after mem_rd, junk otherwise.
        always @(posedge clk) begin
            if (mem_wr[gi])
                ram[mem_addr[gi]] <= mem_wdata[gi] ^ init_word(mem_addr[gi]);
            pipe[0] <= mem_rd[gi] ? (ram[mem_addr[gi]] ^ init_word(mem_addr[gi]))
                                  : {16'hBAD0, $urandom};
            for (int i = 1; i < 7; i++)
                pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[gi] = pipe[LAT-1];

        mesm6_memctl #(.MEM_LATENCY(LAT)) u_dut (
            .clk         (clk),
            .reset       (reset[gi]),
            .ibus_fetch  (ibus_fetch[gi]),
            .ibus_addr   (ibus_addr[gi]),
            .ibus_input  (ibus_input[gi]),
            .ibus_done   (ibus_done[gi]),
            .dbus_read   (dbus_read[gi]),
            .dbus_write  (dbus_write[gi]),
            .dbus_addr   (dbus_addr[gi]),
            .dbus_output (dbus_output[gi]),
            .dbus_input  (dbus_input[gi]),
            .dbus_done   (dbus_done[gi]),
            .mem_addr    (mem_addr[gi]),
            .mem_rd      (mem_rd[gi]),
            .mem_wr      (mem_wr[gi]),
            .mem_wdata   (mem_wdata[gi]),
            .mem_rdata   (mem_rdata[gi]),
            .proto_err   (proto_err[gi])
        );
    end

    function automatic bit any_out(input int k);
        return (|ibus_input[k]) | (|dbus_input[k]) | (|mem_addr[k]) | (|mem_wdata[k]) |
               mem_rd[k] | mem_wr[k] | ibus_done[k] | dbus_done[k] | proto_err[k];
    endfunction

    // Present requests in an idle cycle (called at a negedge) and serve them all.
    task automatic run(input int k, input bit f, input bit r, input bit w,
                       input logic [14:0] fa, input logic [14:0] da,
                       input logic [47:0] dd, input bit repr);
        int win, n, exp_n, rd_n, wr_n, strobe_n, pe_cnt;
        logic [14:0] exp_addr, seen_addr;
        logic [47:0] seen_wdata;
        bit again;
        again = repr;
        ibus_fetch[k] = f;  ibus_addr[k] = fa;
        dbus_read[k]  = r;  dbus_write[k] = w;
        dbus_addr[k]  = da; dbus_output[k] = dd;
        #1;
        while (ibus_fetch[k] || dbus_read[k] || dbus_write[k]) begin
            check("proto_err", 64'(proto_err[k]), 64'(dbus_read[k] && dbus_write[k]));
            if (ibus_fetch[k] && (!(dbus_read[k] || dbus_write[k]) || lost_m[k]))
                win = 0;
            else
                win = dbus_write[k] ? 2 : 1;
            lost_m[k] = ibus_fetch[k] && (win != 0);
            exp_addr = (win == 0) ? ibus_addr[k] : dbus_addr[k];
            if (win == 2) begin
                model_ram[k][exp_addr] = dbus_output[k] ^ init_word(exp_addr);
                exp_n = 2;
            end else begin
                if (win == 0) exp_ibus[k] = model_get(k, exp_addr);
                else          exp_dbus[k] = model_get(k, exp_addr);
                exp_n = lat(k) + 2;
            end

            n = 0; rd_n = 0; wr_n = 0; strobe_n = 0; pe_cnt = 0;
            seen_addr = '0; seen_wdata = '0;
            do begin
                @(negedge clk);
                n++;
                if (mem_rd[k] || mem_wr[k]) begin
                    strobe_n = n; seen_addr = mem_addr[k]; seen_wdata = mem_wdata[k];
                end
                if (mem_rd[k]) rd_n++;
                if (mem_wr[k]) wr_n++;
                if (proto_err[k]) pe_cnt++;
            end while (!(ibus_done[k] || dbus_done[k]) && n < 20);

            $display("txn k=%0d type=%0d addr=%05o done_cycle=%0d", k, win, exp_addr, n);
            check("done_cycle", 64'(n), 64'(exp_n));
            check("done_kind", 64'({ibus_done[k], dbus_done[k]}), (win == 0) ? 64'd2 : 64'd1);
            check("strobes", 64'({8'(rd_n), 8'(wr_n), 8'(strobe_n)}),
                  64'({8'(win != 2), 8'(win == 2), 8'd1}));
            check("mem_addr", 64'(seen_addr), 64'(exp_addr));
            if (win == 2) check("mem_wdata", 64'(seen_wdata), 64'(dbus_output[k]));
            check("proto_busy", 64'(pe_cnt), 64'd0);
            check("ibus_input", 64'(ibus_input[k]), 64'(exp_ibus[k]));
            check("dbus_input", 64'(dbus_input[k]), 64'(exp_dbus[k]));

            if (win == 0) begin
                ibus_fetch[k] = 1'b0;
            end else if (again && ibus_fetch[k]) begin
                again = 1'b0;
            end else begin
                dbus_read[k] = 1'b0; dbus_write[k] = 1'b0;
            end
            @(negedge clk);
            check("done_one_cycle", 64'({ibus_done[k], dbus_done[k]}), 64'd0);
        end
    endtask

    // Fetch aborted by reset in its fourth cycle after arbitration.
    task automatic reset_abort(input int k, input logic [14:0] fa);
        int busy;
        ibus_fetch[k] = 1'b1; ibus_addr[k] = fa;
        repeat (4) @(negedge clk);
        reset[k] = 1'b1; ibus_fetch[k] = 1'b0;
        @(negedge clk);
        reset[k] = 1'b0;
        check("abort_zero", 64'(any_out(k)), 64'd0);
        busy = 0;
        repeat (12) begin
            @(negedge clk);
            busy += int'(ibus_done[k] | dbus_done[k] | mem_rd[k] | mem_wr[k]);
        end
        $display("abort k=%0d busy_cycles=%0d", k, busy);
        check("abort_quiet", 64'(busy), 64'd0);
        check("abort_late", 64'(ibus_input[k]), 64'd0);
        exp_ibus[k] = '0; exp_dbus[k] = '0; lost_m[k] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1; ibus_fetch[k] = 1'b0; ibus_addr[k] = '0;
            dbus_read[k] = 1'b0; dbus_write[k] = 1'b0; dbus_addr[k] = '0;
            dbus_output[k] = '0; exp_ibus[k] = '0; exp_dbus[k] = '0; lost_m[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b0;
            check("reset_outputs", 64'(any_out(k)), 64'd0);
        end

        // Latency 1: read 0o17 after storing 0o1234, full-range write, arbitration, proto error.
        run(0, 0, 0, 1, 15'd0, 15'o00017, 48'o1234, 0);
        run(0, 0, 1, 0, 15'd0, 15'o00017, 48'd0, 0);
        run(0, 0, 0, 1, 15'd0, 15'o77777, 48'hFFFF_FFFF_FFFF, 0);
        run(0, 1, 1, 0, 15'o00100, 15'o77777, 48'd0, 1);
        run(0, 0, 1, 1, 15'd0, 15'o00200, 48'h1234_5678_9ABC, 0);
        run(0, 0, 1, 0, 15'd0, 15'o00200, 48'd0, 0);

        // Latency 7: normal fetch, aborted fetch, fetch after the abort.
        run(1, 1, 0, 0, 15'o00300, 15'd0, 48'd0, 0);
        reset_abort(1, 15'o00017);
        run(1, 1, 0, 0, 15'o00017, 15'd0, 48'd0, 0);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 40; i++) begin
                bit f, r, w;
                logic [14:0] fa, da;
                f = 1'($urandom); r = 1'($urandom); w = ($urandom_range(0, 2) == 0);
                if (!(f || r || w)) f = 1'b1;
                fa = ($urandom_range(0, 1) == 0) ? 15'($urandom_range(0, 7)) : 15'($urandom);
                da = ($urandom_range(0, 1) == 0) ? 15'($urandom_range(0, 7)) : 15'($urandom);
                run(k, f, r, w, fa, da, {16'($urandom), 32'($urandom)}, 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
